// File: rtl/trace_pkg.sv
// Shared types and constants for the PC trace recorder.
package trace_pkg;
  localparam int          SEQ_W    = 16;
  localparam logic [15:0] DROP_MAX = 16'hFFFF;

  typedef struct packed {
    logic [SEQ_W-1:0] seq;
    logic [31:0]      pc;
    logic [31:0]      inst;
  } trace_entry_t;
endpackage

// File: rtl/trace_fifo.sv
// Synchronous first-word-fall-through FIFO; rdata holds its last head while empty.
module trace_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 80
) (
  input  logic                   clk_in,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] head;
  logic             do_pop, do_push;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign count = wr_q - rd_q;
  assign head  = mem_q[rd_q[AW-1:0]];
  assign rdata = empty ? hold_q : head;

  always_comb begin
    do_pop  = pop && !empty;
    // when full, the slot being written is the one being popped this cycle
    do_push = push && (!full || do_pop);
    wr_d    = wr_q + {{AW{1'b0}}, do_push};
    rd_d    = rd_q + {{AW{1'b0}}, do_pop};
    hold_d  = empty ? hold_q : head;
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      wr_q   <= '0;
      rd_q   <= '0;
      hold_q <= '0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      hold_q <= hold_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (do_push && !reset) mem_q[wr_q[AW-1:0]] <= wdata;
  end
endmodule

// File: rtl/pc_trace_recorder.sv
// Records each new committed pc/inst as a sequence-numbered entry; flags drops and CPU halt.
module pc_trace_recorder
  import trace_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int STALL_LIMIT = 8
) (
  input  logic                   clk_in,
  input  logic                   reset,
  input  logic [31:0]            pc,
  input  logic [31:0]            inst,
  input  logic                   trace_en,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [15:0]            out_seq,
  output logic [31:0]            out_pc,
  output logic [31:0]            out_inst,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic [15:0]            drop_cnt,
  output logic                   halted
);
  localparam int            SW        = $clog2(STALL_LIMIT + 1);
  localparam logic [SW-1:0] STALL_MAX = SW'(STALL_LIMIT);

  logic [31:0]      pc_q, pc_d;
  logic             pc_vld_q, pc_vld_d;
  logic             armed_q, armed_d;
  logic [SEQ_W-1:0] seq_q, seq_d;
  logic             overflow_q, overflow_d;
  logic [15:0]      drop_cnt_q, drop_cnt_d;
  logic [SW-1:0]    stall_cnt_q, stall_cnt_d;

  logic         cap, pop, push, drop, full, empty;
  trace_entry_t wentry, head;

  always_comb begin
    cap    = trace_en && (!armed_q || pc != pc_q);
    pop    = !empty && out_ready;
    push   = cap && (!full || pop);
    drop   = cap && !push;
    wentry = '{seq: seq_q, pc: pc, inst: inst};

    pc_d       = pc;
    pc_vld_d   = 1'b1;
    armed_d    = trace_en;
    seq_d      = cap ? seq_q + 16'd1 : seq_q;
    overflow_d = overflow_q | drop;
    drop_cnt_d = (drop && drop_cnt_q != DROP_MAX) ? drop_cnt_q + 16'd1 : drop_cnt_q;

    stall_cnt_d = '0;
    if (pc_vld_q && pc == pc_q)
      stall_cnt_d = (stall_cnt_q == STALL_MAX) ? stall_cnt_q : stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      pc_q        <= '0;
      pc_vld_q    <= 1'b0;
      armed_q     <= 1'b0;
      seq_q       <= '0;
      overflow_q  <= 1'b0;
      drop_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      pc_q        <= pc_d;
      pc_vld_q    <= pc_vld_d;
      armed_q     <= armed_d;
      seq_q       <= seq_d;
      overflow_q  <= overflow_d;
      drop_cnt_q  <= drop_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  trace_fifo #(.DEPTH(DEPTH), .WIDTH($bits(trace_entry_t))) u_fifo (
    .clk_in (clk_in),
    .reset  (reset),
    .push   (push),
    .pop    (pop),
    .wdata  (wentry),
    .rdata  (head),
    .full   (full),
    .empty  (empty),
    .count  (count)
  );

  assign out_valid = !empty;
  assign out_seq   = head.seq;
  assign out_pc    = head.pc;
  assign out_inst  = head.inst;
  assign overflow  = overflow_q;
  assign drop_cnt  = drop_cnt_q;
  assign halted    = (stall_cnt_q == STALL_MAX);
endmodule

// File: tb/tb_pc_trace_recorder.sv
// Directed + random bench for pc_trace_recorder against a queue-based reference model.
module tb_pc_trace_recorder;
  localparam int DEPTH = 16;
  localparam int SL    = 8;

  logic        clk_in = 1'b0;
  logic        reset, trace_en, out_ready;
  logic [31:0] pc, inst;
  logic        out_valid, overflow, halted;
  logic [15:0] out_seq, drop_cnt;
  logic [31:0] out_pc, out_inst;
  logic [4:0]  count;

  pc_trace_recorder #(.DEPTH(DEPTH), .STALL_LIMIT(SL)) dut (
    .clk_in(clk_in), .reset(reset), .pc(pc), .inst(inst), .trace_en(trace_en),
    .out_valid(out_valid), .out_ready(out_ready), .out_seq(out_seq),
    .out_pc(out_pc), .out_inst(out_inst), .count(count), .overflow(overflow),
    .drop_cnt(drop_cnt), .halted(halted)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic [15:0] s;
    logic [31:0] p;
    logic [31:0] i;
  } ent_t;

  int total = 0;
  int bad   = 0;

  // reference state: trace contents as a queue, plus plain counters
  ent_t        q[$];
  ent_t        last_h;
  logic [31:0] m_prev;
  bit          m_pvalid, m_armed, m_ovf;
  int          m_seq, m_drops, m_run;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    q.delete();
    last_h   = '0;
    m_pvalid = 0;
    m_armed  = 0;
    m_ovf    = 0;
    m_seq    = 0;
    m_drops  = 0;
    m_run    = 0;
  endtask

  task automatic tick();
    bit   pop, cap;
    ent_t e, h;
    pop = (q.size() != 0) && out_ready;
    cap = trace_en && (!m_armed || pc != m_prev);
    e   = '{s: 16'(m_seq), p: pc, i: inst};
    @(posedge clk_in);
    if (reset) begin
      model_clear();
    end else begin
      if (q.size() != 0) last_h = q[0];
      if (pop) void'(q.pop_front());
      if (cap) begin
        if (q.size() < DEPTH) q.push_back(e);
        else begin
          m_ovf = 1;
          if (m_drops < 65535) m_drops++;
        end
        m_seq = (m_seq + 1) % 65536;
      end
      if (m_pvalid && pc == m_prev) m_run = (m_run < SL) ? m_run + 1 : SL;
      else m_run = 0;
      m_pvalid = 1;
      m_armed  = trace_en;
    end
    m_prev = pc;
    #1;
    h = (q.size() != 0) ? q[0] : last_h;
    chk("count",    32'(count),     32'(q.size()));
    chk("valid",    32'(out_valid), 32'(q.size() != 0));
    chk("seq",      32'(out_seq),   32'(h.s));
    chk("pc",       out_pc,         h.p);
    chk("inst",     out_inst,       h.i);
    chk("overflow", 32'(overflow),  32'(m_ovf));
    chk("drop_cnt", 32'(drop_cnt),  32'(m_drops));
    chk("halted",   32'(halted),    32'(m_run == SL));
  endtask

  task automatic drive(input logic [31:0] p);
    pc   = p;
    inst = $urandom;
    tick();
  endtask

  initial begin
    reset = 1; trace_en = 0; out_ready = 0; pc = 0; inst = 0;
    model_clear();
    m_prev = 0;
    repeat (3) tick();
    chk("rst_count", 32'(count), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_halt",  32'(halted), 0);

    // linear capture
    reset = 0; trace_en = 1; out_ready = 1;
    drive(32'h00400000);
    chk("lin0_valid", 32'(out_valid), 1);
    chk("lin0_seq",   32'(out_seq), 0);
    chk("lin0_pc",    out_pc, 32'h00400000);
    drive(32'h00400004);
    chk("lin1_seq",   32'(out_seq), 1);
    drive(32'h00400008);
    chk("lin2_seq",   32'(out_seq), 2);
    chk("lin2_pc",    out_pc, 32'h00400008);

    // self-loop and halt
    drive(32'h0040001C);
    chk("loop_seq", 32'(out_seq), 3);
    for (int i = 1; i <= 9; i++) begin
      tick();
      if (i == 7) chk("halt_pre", 32'(halted), 0);
      if (i == 8) chk("halt_rise", 32'(halted), 1);
    end
    chk("loop_single", 32'(count), 0);
    drive(32'h00400020);
    chk("halt_fall", 32'(halted), 0);

    // overflow
    trace_en = 0; tick();
    reset = 1; tick();
    reset = 0; out_ready = 0; trace_en = 1;
    for (int k = 0; k < 20; k++) drive(32'h00500000 + 32'(4 * k));
    chk("ovf_count", 32'(count), 16);
    chk("ovf_flag",  32'(overflow), 1);
    chk("ovf_drops", 32'(drop_cnt), 4);
    chk("ovf_head",  32'(out_seq), 0);

    // full with simultaneous pop
    out_ready = 1;
    drive(32'h00600000);
    chk("fullpop_count", 32'(count), 16);
    chk("fullpop_drops", 32'(drop_cnt), 4);
    chk("fullpop_head",  32'(out_seq), 1);
    trace_en = 0;
    repeat (15) tick();
    chk("drain_last", 32'(out_seq), 20);
    tick();
    chk("drain_empty", 32'(out_valid), 0);
    chk("drain_hold",  32'(out_seq), 20);

    // enable toggle on a stuck pc
    trace_en = 1;
    drive(32'h00400040);
    chk("tog_first", 32'(out_seq), 21);
    repeat (2) tick();
    trace_en = 0;
    repeat (3) tick();
    trace_en = 1;
    tick();
    chk("tog_again", 32'(out_seq), 22);
    chk("tog_count", 32'(count), 1);

    // mid-run reset
    out_ready = 0;
    for (int k = 0; k < 4; k++) drive(32'h00700000 + 32'(4 * k));
    chk("mr_count", 32'(count), 5);
    reset = 1; tick();
    chk("mr_rst_count", 32'(count), 0);
    chk("mr_rst_valid", 32'(out_valid), 0);
    chk("mr_rst_ovf",   32'(overflow), 0);
    chk("mr_rst_drops", 32'(drop_cnt), 0);
    reset = 0;
    drive(32'h00700100);
    chk("mr_seq0", 32'(out_seq), 0);
    chk("mr_valid", 32'(out_valid), 1);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      reset     = ($urandom_range(79) == 0);
      trace_en  = ($urandom_range(7) != 0);
      out_ready = ((i / 100) % 2 == 0) ? ($urandom_range(3) != 0) : ($urandom_range(3) == 0);
      if ($urandom_range(2) != 0) pc = 32'h00400000 + 32'(4 * $urandom_range(7));
      inst = $urandom;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
